uart_receiver: RTL and testbench

- Receive stage downstream of uart_trasmitter. Recovers frames from the serial line driven by the transmitter's tx output.
- Uses the same runtime frame configuration as the transmitter: parity mode, data bits, stop bits.
- Oversamples the line, checks parity and stop bits, and presents a parallel byte with a one-cycle done pulse to the consumer.

---
 rtl/uart_receiver.sv | 129 ++++++++++++
 tb/tb_uart_receiver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start/data/parity/stop recovery with a
// runtime frame format latched at the start of each frame.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       rx_tick,
  input  logic       rst_n,
  input  logic [1:0] parity_type,
  input  logic [3:0] data_bits,
  input  logic       stop_bits,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err
);

  // Handshake: rx_done is a one-cycle valid with no ready; data_out and the
  // error flags are stable from rx_done until the next rx_done or reset.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OVERSAMPLE - 1);

  state_t           state, state_d;
  logic             sync1, rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       shift;
  logic             par_en, par_odd, two_stop;
  logic [2:0]       last_bit;
  logic [2:0]       last_in;
  logic             par_bad, frm_bad, done_pend;
  logic             half_pt, full_pt, last_stop;

  assign half_pt   = (cnt == HALF);
  assign full_pt   = (cnt == FULL);
  assign last_stop = stop_idx || !two_stop;

  // Index of the last data bit after clamping data_bits into 5..8.
  always_comb begin
    last_in = 3'd7;
    if (data_bits < 4'd5)       last_in = 3'd4;
    else if (data_bits <= 4'd8) last_in = 3'(data_bits - 4'd1);
  end

  always_ff @(posedge rx_tick) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (!rxs) state_d = START;
      START:     if (half_pt) state_d = rxs ? IDLE : DATA;
      DATA:      if (full_pt && bit_idx == last_bit) state_d = par_en ? PARITY : STOP;
      PARITY:    if (full_pt) state_d = STOP;
      STOP:      if (full_pt && last_stop) state_d = rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_tick) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      two_stop   <= 1'b0;
      last_bit   <= 3'd7;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      done_pend  <= 1'b0;
      data_out   <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1     <= rx;
      rxs       <= sync1;
      rx_done   <= 1'b0;
      done_pend <= 1'b0;
      // Results are published one cycle after the final stop sample.
      if (done_pend) begin
        rx_done    <= 1'b1;
        data_out   <= shift;
        parity_err <= par_bad;
        frame_err  <= frm_bad;
      end
      if (state == IDLE || (state == START && half_pt) || full_pt) cnt <= '0;
      else                                                         cnt <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          shift    <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          par_bad  <= 1'b0;
          frm_bad  <= 1'b0;
          if (!rxs) begin
            par_en   <= (parity_type == 2'b01) || (parity_type == 2'b10);
            par_odd  <= (parity_type == 2'b10);
            two_stop <= stop_bits;
            last_bit <= last_in;
          end
        end
        DATA: if (full_pt) begin
          shift[bit_idx] <= rxs;
          bit_idx        <= bit_idx + 3'd1;
        end
        PARITY: if (full_pt) par_bad <= (^shift) ^ rxs ^ par_odd;
        STOP: if (full_pt) begin
          if (!rxs) frm_bad <= 1'b1;
          stop_idx <= 1'b1;
          if (last_stop) done_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised bench for uart_receiver: frames are generated from the line
// format rules and a scoreboard checks every rx_done against the model.
module tb_uart_receiver;
  localparam int OS = 16;
  localparam int W  = 42;  // {done_cycle[31:0], frame_err, parity_err, data[7:0]}

  logic       rx_tick = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] parity_type = 2'b00;
  logic [3:0] data_bits = 4'd8;
  logic       stop_bits = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_done, parity_err, frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  uart_receiver #(.OVERSAMPLE(OS), .CNT_W(4)) dut (
    .rx_tick(rx_tick), .rst_n(rst_n), .parity_type(parity_type),
    .data_bits(data_bits), .stop_bits(stop_bits), .rx(rx),
    .data_out(data_out), .rx_done(rx_done), .parity_err(parity_err),
    .frame_err(frame_err)
  );

  // Clock and cycle count: after posedge k, cyc == k.
  always #5 rx_tick = ~rx_tick;
  always @(posedge rx_tick) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge rx_tick);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_cyc(n);
  endtask

  // Drives one frame; the expected result comes straight from the frame format.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic [3:0] db,
                            input logic sb, input logic flip, input logic stop_low,
                            input logic mid_change, input logic do_rst);
    int n, p, k, c;
    logic [7:0] dm;
    logic pbit;
    logic b[$];
    n  = (db < 4'd5) ? 5 : (db > 4'd8) ? 8 : int'(db);
    p  = (pt == 2'd1 || pt == 2'd2) ? 1 : 0;
    k  = sb ? 2 : 1;
    dm = d & 8'((1 << n) - 1);
    pbit = (^dm) ^ (pt == 2'd2) ^ flip;
    b = {};
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) b.push_back(dm[i]);
    if (p == 1) b.push_back(pbit);
    b.push_back(!stop_low);
    if (k == 2) b.push_back(1'b1);
    parity_type = pt;
    data_bits   = db;
    stop_bits   = sb;
    c = cyc + 1;
    if (!do_rst) exp_q.push_back({32'(c + 11 + OS * (n + p + k)), stop_low, (p == 1) && flip, dm});
    for (int j = 0; j < b.size(); j++) begin
      rx = b[j];
      for (int t = 0; t < OS; t++) begin
        if (mid_change && j == 2 && t == 0) begin
          parity_type = 2'($urandom_range(0, 3));
          data_bits   = 4'($urandom_range(0, 15));
          stop_bits   = 1'($urandom_range(0, 1));
        end
        if (do_rst && j == 4 && t == 5) begin
          rst_n = 1'b0;
          wait_cyc(1);
          rst_n = 1'b1;
          @(negedge rx_tick);
          check("rst_mid_data_out", 32'(data_out), 32'h0);
          check("rst_mid_rx_done", 32'(rx_done), 32'h0);
          check("rst_mid_parity_err", 32'(parity_err), 32'h0);
          check("rst_mid_frame_err", 32'(frame_err), 32'h0);
        end
        wait_cyc(1);
      end
    end
  endtask

  // Monitor: every rx_done pulse must match the oldest expected frame.
  always @(negedge rx_tick) begin
    if (rx_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got rx_done=1 at cycle %0d expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(mon_e[7:0]));
        check("parity_err", 32'(parity_err), 32'(mon_e[8]));
        check("frame_err", 32'(frame_err), 32'(mon_e[9]));
        check("done_cycle", 32'(cyc), mon_e[41:10]);
      end
    end
  end

  initial begin
    logic stop_low, sb;
    int gap;
    wait_cyc(3);
    @(negedge rx_tick);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    wait_cyc(1);
    rst_n = 1'b1;
    idle(10);

    send_frame(8'hAA, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(10);
    send_frame(8'hAA, 2'b00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(5);
    send_frame(8'hAA, 2'b01, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(5);
    send_frame(8'hAA, 2'b10, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(5);
    send_frame(8'h55, 2'b01, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(5);
    send_frame(8'h55, 2'b01, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(5);

    // Stop bit low, then the line held low for 40 bit times.
    send_frame(8'h3C, 2'b00, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rx = 1'b0;
    wait_cyc(40 * OS);
    idle(20);
    send_frame(8'h5A, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(10);

    // Start glitch shorter than half a bit.
    rx = 1'b0;
    wait_cyc(OS / 2 - 2);
    idle(40);
    send_frame(8'h81, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(10);

    // Leave non-zero outputs, then reset during data bit 3 of a frame.
    send_frame(8'h3C, 2'b00, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); idle(20);
    send_frame(8'hF8, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); idle(40);
    send_frame(8'hC3, 2'b10, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(5);

    for (int f = 0; f < 30; f++) begin
      sb       = 1'($urandom_range(0, 1));
      stop_low = ($urandom_range(0, 3) == 0);
      send_frame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), sb, 1'($urandom_range(0, 1)),
                 stop_low, 1'($urandom_range(0, 1)), 1'b0);
      gap = $urandom_range(0, 12);
      if (stop_low && !sb && gap < 4) gap = 4;
      if (gap > 0) idle(gap);
    end
    idle(4);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_cyc(1);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL missing_done: got %0d frames outstanding expected 0", exp_q.size());
    end
    idle(50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
